dmem_ctrl: RTL and testbench

//  Sequential data-memory controller between cpu_core's load/store port and the single-port data BRAM.
//  - Accepts one load/store request at a time through a valid/ready handshake.
//  - Performs byte-lane steering and byte-enable generation for SB/SH/SW.
//  - Waits out the BRAM read latency, then returns sign- or zero-extended LB/LH/LW/LBU/LHU data as a one-cycle response pulse.

---
 rtl/dmem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequential data-memory controller between the cpu_core load/store
// port and a single-port 32-bit data BRAM.
//
// Handshake: a request is accepted on a cycle where req_valid && req_ready.
// req_ready is high only in IDLE. Responses have no backpressure: rsp_valid is
// a single-cycle pulse that the core consumes unconditionally.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests skip the BRAM. They answer at T+1
//               with misalign_err=1 and rsp_rdata=0.
//   undefined - low address bits are forced to natural alignment, and
//               misalign_err is constant 0.
//
// The FSM state is visible as the 'state' signal for hierarchical probing.
module dmem_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int BRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign_err,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t state, state_nxt;

  // Request fields kept for the load return path
  logic       we_q, uns_q;
  logic [1:0] size_q, off_q, cnt_q;

  // Next values of the registered outputs and bookkeeping
  logic              ready_d, rsp_valid_d, bram_en_d;
  logic [31:0]       rsp_rdata_d, bram_din_d;
  logic [3:0]        bram_we_d;
  logic [ADDR_W-1:0] bram_addr_d;
  logic [1:0]        cnt_d;

  logic       accept, is_byte, is_half, misaligned;
  logic [1:0] off_eff;
  logic [31:0] shifted, ext;

  // Upper byte-address bits are deliberately ignored (address wrap)
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept  = req_valid && req_ready;
  assign is_byte = (req_size == 2'b00);
  assign is_half = (req_size == 2'b01);
  // Reserved size 2'b11 behaves as a word
  assign off_eff = is_byte ? req_addr[1:0] :
                   is_half ? {req_addr[1], 1'b0} : 2'b00;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = (is_half && req_addr[0]) ||
                      (!is_byte && !is_half && (req_addr[1:0] != 2'b00));

  // Error flag rides along with the T+1 trap response only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_err <= 1'b0;
    else      misalign_err <= accept && misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Lane-shift the returned word and extend it to 32 bits
  always_comb begin
    shifted = bram_dout >> {off_q, 3'b000};
    ext     = shifted;
    if (size_q == 2'b00)
      ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (size_q == 2'b01)
      ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  // Next state and next registered-output values
  always_comb begin
    state_nxt   = state;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    bram_en_d   = 1'b0;
    bram_we_d   = 4'h0;
    bram_addr_d = '0;
    bram_din_d  = 32'h0;
    cnt_d       = cnt_q;
    case (state)
      IDLE: begin
        if (!accept) begin
          ready_d = 1'b1;
        end else if (misaligned) begin
          state_nxt   = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_nxt   = ACCESS;
          bram_en_d   = 1'b1;
          bram_addr_d = req_addr[ADDR_W+1:2];
          if (req_we) begin
            // Stores complete in the ACCESS cycle itself
            rsp_valid_d = 1'b1;
            if (is_byte) begin
              bram_we_d  = 4'b0001 << off_eff;
              bram_din_d = {4{req_wdata[7:0]}};
            end else if (is_half) begin
              bram_we_d  = 4'b0011 << off_eff;
              bram_din_d = {2{req_wdata[15:0]}};
            end else begin
              bram_we_d  = 4'b1111;
              bram_din_d = req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_nxt = IDLE;
          ready_d   = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_d     = 2'(BRAM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_nxt   = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ext;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        ready_d   = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ready_d   = 1'b1;
      end
    endcase
  end

  // State, output and request-field registers; reset aborts any access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      bram_en   <= 1'b0;
      bram_we   <= 4'h0;
      bram_addr <= '0;
      bram_din  <= 32'h0;
      cnt_q     <= 2'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
    end else begin
      state     <= state_nxt;
      req_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      bram_en   <= bram_en_d;
      bram_we   <= bram_we_d;
      bram_addr <= bram_addr_d;
      bram_din  <= bram_din_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        off_q  <= off_eff;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with a 1-cycle-latency BRAM model.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_ready, rsp_valid, misalign_err, bram_en;
  logic [31:0] rsp_rdata, bram_din;
  logic [31:0] bram_dout = 32'h0;
  logic [3:0]  bram_we;
  logic [4:0]  bram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [32];

  dmem_ctrl #(.ADDR_W(5), .BRAM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign_err(misalign_err),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // Clock
  always #5 clk = ~clk;

  // BRAM model: byte-write, read-first, one clock read latency
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      bram_dout <= mem[bram_addr];
    end
  end

  initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;

  // Driver: one store; samples the ACCESS-cycle outputs, returns in IDLE
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          output logic [3:0] we, output logic en, output logic [4:0] ad,
                          output logic [31:0] din, output logic rv, output logic [31:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_size = sz;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    we = bram_we; en = bram_en; ad = bram_addr; din = bram_din; rv = rsp_valid; rd = rsp_rdata;
    @(negedge clk);
  endtask

  // Monitor: wait (bounded) for rsp_valid starting at the cycle after accept
  task automatic wait_rsp(output logic [31:0] data, output int lat, output logic err,
                          output int en_cnt);
    bit found = 0;
    lat = 1; en_cnt = 0; data = 32'hx; err = 1'bx;
    while (!found && lat < 12) begin
      if (bram_en) en_cnt++;
      if (rsp_valid) begin
        found = 1; data = rsp_rdata; err = misalign_err;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!found) lat = -1;
    @(negedge clk);
  endtask

  // Driver: one load followed by its response
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         output logic [31:0] data, output int lat, output logic err,
                         output int en_cnt);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_size = sz; req_unsigned = uns;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(data, lat, err, en_cnt);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (bram_en !== 1'b0 || bram_we !== 4'h0) begin n_fail++; $display("FAIL reset_bram_ctl: got en=%b we=%h want 0/0", bram_en, bram_we); end
    n_checks++; if (bram_addr !== 5'h0 || bram_din !== 32'h0 || rsp_rdata !== 32'h0 || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h din=%h rdata=%h err=%b want zeros", bram_addr, bram_din, rsp_rdata, misalign_err); end
    rst = 1'b1;
  endtask

  task automatic test_word;
    logic [3:0] we; logic en, rv, err; logic [4:0] ad; logic [31:0] din, rd, data; int lat, enc;
    do_store(32'h08, 32'hDEADBEEF, 2'b10, we, en, ad, din, rv, rd);
    n_checks++; if (we !== 4'b1111) begin n_fail++; $display("FAIL sw_we: got %b want 1111", we); end
    n_checks++; if (en !== 1'b1 || ad !== 5'd2) begin n_fail++; $display("FAIL sw_en_addr: got en=%b addr=%0d want 1/2", en, ad); end
    n_checks++; if (din !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_din: got %h want deadbeef", din); end
    n_checks++; if (rv !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_rsp: got valid=%b rdata=%h want 1/0", rv, rd); end
    do_load(32'h08, 2'b10, 1'b0, data, lat, err, enc);
    n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", data); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_checks++; if (enc !== 1 || err !== 1'b0) begin n_fail++; $display("FAIL lw_en_err: got en_cycles=%0d err=%b want 1/0", enc, err); end
  endtask

  task automatic test_byte;
    logic [3:0] we; logic en, rv, err; logic [4:0] ad; logic [31:0] din, rd, data; int lat, enc;
    do_store(32'h0C, 32'h11223344, 2'b10, we, en, ad, din, rv, rd);
    do_store(32'h0D, 32'h000000A5, 2'b00, we, en, ad, din, rv, rd);
    n_checks++; if (we !== 4'b0010) begin n_fail++; $display("FAIL sb_we: got %b want 0010", we); end
    n_checks++; if (din !== 32'hA5A5A5A5 || ad !== 5'd3) begin n_fail++; $display("FAIL sb_din: got din=%h addr=%0d want a5a5a5a5/3", din, ad); end
    do_load(32'h0D, 2'b00, 1'b0, data, lat, err, enc);
    n_checks++; if (data !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_data: got %h want ffffffa5", data); end
    do_load(32'h0D, 2'b00, 1'b1, data, lat, err, enc);
    n_checks++; if (data !== 32'h000000A5) begin n_fail++; $display("FAIL lbu_data: got %h want 000000a5", data); end
    do_load(32'h0C, 2'b10, 1'b1, data, lat, err, enc);
    n_checks++; if (data !== 32'h1122A544) begin n_fail++; $display("FAIL sb_other_lanes: got %h want 1122a544", data); end
  endtask

  task automatic test_half;
    logic [3:0] we; logic en, rv, err; logic [4:0] ad; logic [31:0] din, rd, data; int lat, enc;
    do_store(32'h12, 32'h00008001, 2'b01, we, en, ad, din, rv, rd);
    n_checks++; if (we !== 4'b1100) begin n_fail++; $display("FAIL sh_we: got %b want 1100", we); end
    n_checks++; if (din !== 32'h80018001) begin n_fail++; $display("FAIL sh_din: got %h want 80018001", din); end
    do_load(32'h12, 2'b01, 1'b0, data, lat, err, enc);
    n_checks++; if (data !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_data: got %h want ffff8001", data); end
    do_load(32'h12, 2'b01, 1'b1, data, lat, err, enc);
    n_checks++; if (data !== 32'h00008001) begin n_fail++; $display("FAIL lhu_data: got %h want 00008001", data); end
  endtask

  task automatic test_misalign;
    logic [3:0] we; logic en, rv, err; logic [4:0] ad; logic [31:0] din, rd, data; int lat, enc;
    do_store(32'h04, 32'hCAFEF00D, 2'b10, we, en, ad, din, rv, rd);
    do_load(32'h06, 2'b10, 1'b0, data, lat, err, enc);
`ifdef DMEM_MISALIGN_TRAP_EN
    n_checks++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL mis_trap: got lat=%0d err=%b want 1/1", lat, err); end
    n_checks++; if (data !== 32'h0 || enc !== 0) begin n_fail++; $display("FAIL mis_nobram: got data=%h en_cycles=%0d want 0/0", data, enc); end
`else
    n_checks++; if (data !== 32'hCAFEF00D || err !== 1'b0) begin n_fail++; $display("FAIL mis_align: got data=%h err=%b want cafef00d/0", data, err); end
    n_checks++; if (lat !== 3 || enc !== 1) begin n_fail++; $display("FAIL mis_timing: got lat=%0d en_cycles=%0d want 3/1", lat, enc); end
`endif
  endtask

  task automatic test_reset_abort;
    int pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h04; req_size = 2'b10; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || bram_en !== 1'b0 || bram_we !== 4'h0 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL abort_outputs: got valid=%b en=%b we=%h rdata=%h want zeros", rsp_valid, bram_en, bram_we, rsp_rdata); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    n_checks++; if (pulses !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_no_rsp: got pulses=%0d ready=%b want 0/1", pulses, req_ready); end
  endtask

  task automatic test_back_to_back;
    int acc = 0, gap = 0, cyc = 0, pulses = 0, lat, enc;
    logic [31:0] first = 32'hx, data; logic err;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08; req_size = 2'b10; req_unsigned = 1'b0;
    while (acc < 2 && cyc < 20) begin
      if (rsp_valid) begin pulses++; first = rsp_rdata; end
      if (req_ready) acc++;
      else if (acc == 1) gap++;
      if (acc < 2) begin @(negedge clk); cyc++; end
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(data, lat, err, enc);
    n_checks++; if (acc !== 2 || gap !== 3) begin n_fail++; $display("FAIL b2b_gap: got accepts=%0d busy=%0d want 2/3", acc, gap); end
    n_checks++; if (pulses !== 1 || first !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_first: got pulses=%0d data=%h want 1/deadbeef", pulses, first); end
    n_checks++; if (data !== 32'hDEADBEEF || lat !== 3) begin n_fail++; $display("FAIL b2b_second: got data=%h lat=%0d want deadbeef/3", data, lat); end
  endtask

  task automatic test_wrap;
    logic [3:0] we; logic en, rv, err; logic [4:0] ad; logic [31:0] din, rd, data; int lat, enc;
    do_store(32'h80, 32'h5A5A0F0F, 2'b10, we, en, ad, din, rv, rd);
    n_checks++; if (ad !== 5'd0 || en !== 1'b1) begin n_fail++; $display("FAIL wrap_addr: got addr=%0d en=%b want 0/1", ad, en); end
    do_load(32'h00, 2'b10, 1'b0, data, lat, err, enc);
    n_checks++; if (data !== 32'h5A5A0F0F) begin n_fail++; $display("FAIL wrap_readback: got %h want 5a5a0f0f", data); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_misalign;
    test_reset_abort;
    test_back_to_back;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
